// File: rtl/msrv32_store_buffer_ahb_if.sv
// Store-unit request and AHB-Lite write-master signals of the store buffer,
// grouped so the buffer and its environment connect through a single port.
interface msrv32_store_buffer_ahb_if;
    logic        wr_req_in;
    logic [31:0] d_addr_in;
    logic [31:0] data_in;
    logic [3:0]  wr_mask_in;
    logic        hready_in;
    logic        hresp_in;
    logic [31:0] haddr_out;
    logic [1:0]  htrans_out;
    logic        hwrite_out;
    logic [2:0]  hsize_out;
    logic [31:0] hwdata_out;
    logic        stall_out;
    logic        idle_out;
    logic        bus_err_out;

    modport master (
        input  wr_req_in, d_addr_in, data_in, wr_mask_in, hready_in, hresp_in,
        output haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out,
        output stall_out, idle_out, bus_err_out
    );

    modport slave (
        output wr_req_in, d_addr_in, data_in, wr_mask_in, hready_in, hresp_in,
        input  haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out,
        input  stall_out, idle_out, bus_err_out
    );
endinterface

// File: rtl/msrv32_store_buffer_ahb.sv
// Two-entry store buffer that drains masked word stores onto AHB-Lite as
// single NONSEQ write transfers, one store per two cycles with no wait states.
module msrv32_store_buffer_ahb (
    input  logic                      ms_riscv32_mp_clk_in,
    input  logic                      ms_riscv32_mp_rst_in,
    msrv32_store_buffer_ahb_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [29:0] addr_q [2];
    logic [31:0] data_q [2];
    logic [3:0]  mask_q [2];
    logic        wptr_q, rptr_q;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] dph_data_q;
    logic        err_q;
    logic        push, pop;
    logic [4:0]  head_dec;
    logic        unused_addr_lsb;

    // Returns {hsize, haddr[1:0]} for a byte-lane mask; odd patterns go out as a word.
    function automatic logic [4:0] decode_mask(input logic [3:0] m);
        case (m)
            4'b1111: return {3'b010, 2'b00};
            4'b0011: return {3'b001, 2'b00};
            4'b1100: return {3'b001, 2'b10};
            4'b0001: return {3'b000, 2'b00};
            4'b0010: return {3'b000, 2'b01};
            4'b0100: return {3'b000, 2'b10};
            4'b1000: return {3'b000, 2'b11};
            default: return {3'b010, 2'b00};
        endcase
    endfunction

    assign unused_addr_lsb = ^bus.d_addr_in[1:0];

    // A full buffer refuses the push even if the head pops this cycle.
    assign push = bus.wr_req_in && (bus.wr_mask_in != 4'b0000) && (cnt_q != 2'd2);
    assign pop  = (state_q == S_ADDR) && bus.hready_in;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + 2'd1;
        else if (pop && !push)
            cnt_d = cnt_q - 2'd1;
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (push)
                wptr_q <= ~wptr_q;
            if (pop)
                rptr_q <= ~rptr_q;
            if ((state_q == S_DATA) && bus.hready_in && bus.hresp_in)
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push) begin
            addr_q[wptr_q] <= bus.d_addr_in[31:2];
            data_q[wptr_q] <= bus.data_in;
            mask_q[wptr_q] <= bus.wr_mask_in;
        end
        if (pop)
            dph_data_q <= data_q[rptr_q];
    end

    // Looking at the next count lets a fresh push reach the bus one cycle later.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cnt_d != 2'd0) state_d = S_ADDR;
            S_ADDR: if (bus.hready_in) state_d = S_DATA;
            S_DATA: if (bus.hready_in) state_d = (cnt_d != 2'd0) ? S_ADDR : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign head_dec = decode_mask(mask_q[rptr_q]);

    always_comb begin
        bus.haddr_out  = 32'h0;
        bus.htrans_out = 2'b00;
        bus.hwrite_out = 1'b0;
        bus.hsize_out  = 3'b000;
        bus.hwdata_out = 32'h0;
        case (state_q)
            S_ADDR: begin
                bus.haddr_out  = {addr_q[rptr_q], head_dec[1:0]};
                bus.htrans_out = 2'b10;
                bus.hwrite_out = 1'b1;
                bus.hsize_out  = head_dec[4:2];
            end
            S_DATA: bus.hwdata_out = dph_data_q;
            default: ;
        endcase
    end

    assign bus.stall_out   = (cnt_q == 2'd2);
    assign bus.idle_out    = (state_q == S_IDLE) && (cnt_q == 2'd0);
    assign bus.bus_err_out = err_q;
endmodule

// File: tb/tb_msrv32_store_buffer_ahb.sv
// Directed bench for the AHB store buffer: single/byte stores, back-to-back
// with wait states, error response, mid-transfer reset and empty masks.
module tb_msrv32_store_buffer_ahb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    msrv32_store_buffer_ahb_if bus();

    msrv32_store_buffer_ahb dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .bus                  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m);
        bus.wr_req_in  = req;
        bus.d_addr_in  = a;
        bus.data_in    = d;
        bus.wr_mask_in = m;
    endtask

    task automatic test_reset();
        logic [73:0] obs;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        obs = {bus.haddr_out, bus.htrans_out, bus.hwrite_out, bus.hsize_out,
               bus.hwdata_out, bus.stall_out, bus.idle_out, bus.bus_err_out};
        total++;
        if (obs !== {32'h0, 2'b00, 1'b0, 3'b000, 32'h0, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got %h want haddr/htrans/hwrite/hsize/hwdata=0 idle=1", obs);
        end
    endtask

    task automatic test_single_word();
        drive(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'b0000);
        total++;
        if ({bus.htrans_out, bus.hwrite_out, bus.haddr_out, bus.hsize_out, bus.idle_out}
            !== {2'b10, 1'b1, 32'h100, 3'b010, 1'b0}) begin
            bad++;
            $display("FAIL single_addr_phase: htrans=%b hwrite=%b haddr=%h hsize=%b idle=%b want 10 1 00000100 010 0",
                     bus.htrans_out, bus.hwrite_out, bus.haddr_out, bus.hsize_out, bus.idle_out);
        end
        step();
        total++;
        if ({bus.htrans_out, bus.hwdata_out} !== {2'b00, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL single_data_phase: htrans=%b hwdata=%h want 00 deadbeef",
                     bus.htrans_out, bus.hwdata_out);
        end
        step();
        total++;
        if ({bus.idle_out, bus.htrans_out} !== {1'b1, 2'b00}) begin
            bad++;
            $display("FAIL single_idle: idle=%b htrans=%b want 1 00", bus.idle_out, bus.htrans_out);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] va [5] = '{32'h200, 32'h303, 32'h400, 32'h500, 32'h600};
        logic [31:0] vd [5] = '{32'h00AB0000, 32'h0000BEEF, 32'hCAFE0000, 32'h12345678, 32'h99000000};
        logic [3:0]  vm [5] = '{4'b0100, 4'b0011, 4'b1100, 4'b0101, 4'b1000};
        logic [31:0] ea [5] = '{32'h202, 32'h300, 32'h402, 32'h500, 32'h603};
        logic [2:0]  es [5] = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b000};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, va[i], vd[i], vm[i]);
            step();
            drive(1'b0, 32'h0, 32'h0, 4'b0000);
            total++;
            if ({bus.htrans_out, bus.haddr_out, bus.hsize_out} !== {2'b10, ea[i], es[i]}) begin
                bad++;
                $display("FAIL lane_addr[%0d]: htrans=%b haddr=%h hsize=%b want 10 %h %b",
                         i, bus.htrans_out, bus.haddr_out, bus.hsize_out, ea[i], es[i]);
            end
            step();
            total++;
            if (bus.hwdata_out !== vd[i]) begin
                bad++;
                $display("FAIL lane_data[%0d]: hwdata=%h want %h", i, bus.hwdata_out, vd[i]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic        treq [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int          tsel [12] = '{0, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0};
        logic        thr  [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0]  etr  [12] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
        logic [31:0] ead  [12] = '{32'h0, 32'h1000, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h2000, 32'h0, 32'h3000, 32'h0, 32'h0};
        logic [31:0] ewd  [12] = '{32'h0, 32'h0, 32'h0, 32'h11111111, 32'h11111111, 32'h11111111,
                                   32'h11111111, 32'h0, 32'h22222222, 32'h0, 32'h33333333, 32'h0};
        logic        est  [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] sa   [3]  = '{32'h1000, 32'h2000, 32'h3000};
        logic [31:0] sd   [3]  = '{32'h11111111, 32'h22222222, 32'h33333333};
        for (int c = 0; c < 12; c++) begin
            total++;
            if ({bus.htrans_out, bus.haddr_out, bus.hwdata_out, bus.stall_out}
                !== {etr[c], ead[c], ewd[c], est[c]}) begin
                bad++;
                $display("FAIL b2b_cycle[%0d]: htrans=%b haddr=%h hwdata=%h stall=%b want %b %h %h %b",
                         c, bus.htrans_out, bus.haddr_out, bus.hwdata_out, bus.stall_out,
                         etr[c], ead[c], ewd[c], est[c]);
            end
            drive(treq[c], sa[tsel[c]], sd[tsel[c]], treq[c] ? 4'b1111 : 4'b0000);
            bus.hready_in = thr[c];
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 4'b0000);
        bus.hready_in = 1'b1;
        total++;
        if (bus.idle_out !== 1'b1) begin
            bad++;
            $display("FAIL b2b_drained: idle=%b want 1", bus.idle_out);
        end
    endtask

    task automatic test_error();
        drive(1'b1, 32'h4000, 32'hAAAA5555, 4'b1111);
        step();
        drive(1'b1, 32'h4004, 32'h5555AAAA, 4'b1111);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'b0000);
        total++;
        if ({bus.hwdata_out, bus.bus_err_out} !== {32'hAAAA5555, 1'b0}) begin
            bad++;
            $display("FAIL err_before: hwdata=%h bus_err=%b want aaaa5555 0", bus.hwdata_out, bus.bus_err_out);
        end
        bus.hresp_in = 1'b1;
        step();
        bus.hresp_in = 1'b0;
        total++;
        if ({bus.bus_err_out, bus.htrans_out, bus.haddr_out} !== {1'b1, 2'b10, 32'h4004}) begin
            bad++;
            $display("FAIL err_set_second_issued: bus_err=%b htrans=%b haddr=%h want 1 10 00004004",
                     bus.bus_err_out, bus.htrans_out, bus.haddr_out);
        end
        step();
        total++;
        if (bus.hwdata_out !== 32'h5555AAAA) begin
            bad++;
            $display("FAIL err_second_data: hwdata=%h want 5555aaaa", bus.hwdata_out);
        end
        step();
        total++;
        if ({bus.idle_out, bus.bus_err_out} !== 2'b11) begin
            bad++;
            $display("FAIL err_sticky: idle=%b bus_err=%b want 1 1", bus.idle_out, bus.bus_err_out);
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic [73:0] obs;
        drive(1'b1, 32'h5000, 32'h55555555, 4'b1111);
        step();
        drive(1'b1, 32'h6000, 32'h66666666, 4'b1111);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'b0000);
        total++;
        if ({bus.htrans_out, bus.hwdata_out, bus.bus_err_out} !== {2'b00, 32'h55555555, 1'b1}) begin
            bad++;
            $display("FAIL rst_pre_data: htrans=%b hwdata=%h bus_err=%b want 00 55555555 1",
                     bus.htrans_out, bus.hwdata_out, bus.bus_err_out);
        end
        rst = 1'b1;
        bus.hready_in = 1'b0;
        step();
        rst = 1'b0;
        bus.hready_in = 1'b1;
        obs = {bus.haddr_out, bus.htrans_out, bus.hwrite_out, bus.hsize_out,
               bus.hwdata_out, bus.stall_out, bus.idle_out, bus.bus_err_out};
        total++;
        if (obs !== {32'h0, 2'b00, 1'b0, 3'b000, 32'h0, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL rst_mid_outputs: got %h want all zero except idle=1", obs);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if ({bus.htrans_out, bus.idle_out} !== {2'b00, 1'b1}) begin
                bad++;
                $display("FAIL rst_discard[%0d]: htrans=%b idle=%b want 00 1", k, bus.htrans_out, bus.idle_out);
            end
        end
    endtask

    task automatic test_zero_mask();
        drive(1'b1, 32'h700, 32'h77777777, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if ({bus.htrans_out, bus.idle_out, bus.stall_out} !== {2'b00, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL zero_mask[%0d]: htrans=%b idle=%b stall=%b want 00 1 0",
                         k, bus.htrans_out, bus.idle_out, bus.stall_out);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 4'b0000);
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0, 4'b0000);
        bus.hready_in = 1'b1;
        bus.hresp_in  = 1'b0;
        test_reset();
        test_single_word();
        test_byte_lanes();
        test_back_to_back();
        test_error();
        test_reset_mid_transfer();
        test_zero_mask();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/msrv32_store_buffer_ahb.md
MSRV32_STORE_BUFFER_AHB -- requirements
Module: msrv32_store_buffer_ahb

Interface
REQ-001 SHALL have port ms_riscv32_mp_clk_in, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port ms_riscv32_mp_rst_in, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port wr_req_in, input, 1, store request from store unit.
REQ-004 SHALL have port d_addr_in, input, 32, word-aligned store address; bits [1:0] ignored.
REQ-005 SHALL have port data_in, input, 32, lane-positioned store data.
REQ-006 SHALL have port wr_mask_in, input, 4, byte-lane write mask.
REQ-007 SHALL have port hready_in, input, 1, AHB-Lite HREADY.
REQ-008 SHALL have port hresp_in, input, 1, AHB-Lite HRESP; 1 = ERROR.
REQ-009 SHALL have port haddr_out, output, 32, AHB HADDR (byte address).
REQ-010 SHALL have port htrans_out, output, 2, AHB HTRANS; only 2'b00 IDLE and 2'b10 NONSEQ are used.
REQ-011 SHALL have port hwrite_out, output, 1, AHB HWRITE.
REQ-012 SHALL have port hsize_out, output, 3, AHB HSIZE.
REQ-013 SHALL have port hwdata_out, output, 32, AHB HWDATA.
REQ-014 SHALL have port stall_out, output, 1, buffer full; requester must hold its request.
REQ-015 SHALL have port idle_out, output, 1, buffer empty and bus idle (fence complete).
REQ-016 SHALL have port bus_err_out, output, 1, sticky AHB error flag.

Function
REQ-017 SHALL hold a 2-entry FIFO of {address, data, mask}, with 1-bit read/write pointers and a 2-bit count.
REQ-018 SHALL push when wr_req_in=1, wr_mask_in!=0 and count<2; a push is ignored when wr_mask_in=0 or count=2, including when a pop occurs in the same cycle.
REQ-019 SHALL drive stall_out=1 exactly when count=2 (combinational from count).
REQ-020 SHALL implement FSM states IDLE, ADDR and DATA, with state held in flops.
REQ-021 SHALL transition IDLE->ADDR on the clock edge after count becomes nonzero; an entry pushed in cycle N is first visible on the bus in cycle N+1.
REQ-022 SHALL, in ADDR, drive htrans_out=2'b10, hwrite_out=1, and haddr_out/hsize_out from the FIFO head.
REQ-023 SHALL, when hready_in=1 in ADDR, pop the head into the data-phase register and go to DATA; when hready_in=0, hold ADDR with outputs stable.
REQ-024 SHALL, in DATA, drive htrans_out=2'b00 and hwdata_out from the data-phase register, holding them while hready_in=0.
REQ-025 SHALL, when hready_in=1 in DATA, sample hresp_in and go to ADDR if count>0, else IDLE.
REQ-026 SHALL, in IDLE, drive htrans_out=2'b00 and hwrite_out=0.
REQ-027 SHALL derive hsize_out and haddr_out[1:0] from the mask:
- 4'b1111 -> size 3'b010, offset 00
- 4'b0011 -> 3'b001, offset 00
- 4'b1100 -> 3'b001, offset 10
- one-hot bit k -> 3'b000, offset k
- any other nonzero mask -> word (3'b010, offset 00)
REQ-028 SHALL set bus_err_out=1 when hresp_in=1 is sampled per REQ-025; it stays set until reset, and the buffer continues draining.
REQ-029 SHALL drive idle_out=1 exactly when state=IDLE and count=0.
REQ-030 SHALL achieve a zero-wait-state throughput of one store per 2 cycles.

Reset
REQ-031 SHALL, when ms_riscv32_mp_rst_in=1 at a clock edge in any state, including mid-transfer, force:
- state IDLE, count 0, pointers 0
- haddr_out 0, htrans_out 00, hwrite_out 0, hsize_out 000, hwdata_out 0
- stall_out 0, idle_out 1, bus_err_out 0
REQ-032 SHALL discard buffered entries on reset without completing them.

Verification
REQ-033 SHALL be covered by these directed scenarios:
- Single word store: addr 0x100, data 0xDEADBEEF, mask 1111, hready=1 -> next cycle HTRANS=10, HADDR=0x100, HSIZE=010; following cycle HWDATA=0xDEADBEEF; then idle_out=1.
- Byte store: mask 0100, addr 0x200, data 0x00AB0000 -> HADDR=0x202, HSIZE=000.
- Back-to-back with hready=0 for 3 data-phase cycles, three pushes -> stall_out=1 after the second push; third store accepted only once the first pops; bus order preserved.
- Error: hresp=1 during DATA of store 1 of 2 -> bus_err_out=1 from the next cycle; store 2 still issued.
- Reset asserted in DATA with 1 entry queued -> next cycle all outputs at reset values, count=0.
- Mask 0000 with wr_req_in=1 -> no bus transfer, idle_out stays 1.
